axi_read_arbiter: RTL and testbench

//  Shares the core's single AXI read master (ar/r channels) between the instruction fetch and data

---
 rtl/axi_read_arbiter.sv | 154 +++++++++++++++
 tb/tb_axi_read_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read master (AR/R channels) between the
// instruction-fetch and data-access miss units. One burst in flight at a time.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, simultaneous
// requests alternate between the two sides. When it is undefined, the data
// side always wins ties.
module axi_read_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    // instruction side
    input  logic        i_arvalid,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    // data side
    input  logic        d_arvalid,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    // AXI master
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic [1:0]  m_arlock,
    output logic [3:0]  m_arcache,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic        err_rid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } st_t;

    st_t  st, st_nxt;
    logic gnt, gnt_nxt;            // 0 = instruction, 1 = data
    logic last_gnt, last_gnt_nxt;
    logic err_rid_nxt;
    logic [3:0] gnt_id;

    assign gnt_id = gnt ? DATA_ID : INST_ID;

    // Fixed AR attributes: INCR bursts, normal access, unprivileged
    assign m_arburst = 2'b01;
    assign m_arlock  = '0;
    assign m_arcache = '0;
    assign m_arprot  = '0;

    // R data and last are broadcast; only the granted side sees rvalid
    assign i_rdata = m_rdata;
    assign i_rlast = m_rlast;
    assign d_rdata = m_rdata;
    assign d_rlast = m_rlast;

    // rresp is intentionally dropped; last_gnt only matters for round-robin
`ifdef ARB_ROUND_ROBIN_EN
    logic unused_sig;
    assign unused_sig = ^m_rresp;
`else
    logic unused_sig;
    assign unused_sig = ^{m_rresp, last_gnt};
`endif

    // State register: FSM state, grant, previous grant and sticky rid error
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            st       <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            err_rid  <= 1'b0;
        end else begin
            st       <= st_nxt;
            gnt      <= gnt_nxt;
            last_gnt <= last_gnt_nxt;
            err_rid  <= err_rid_nxt;
        end
    end

    // Next-state logic, arbitration and channel steering
    always_comb begin
        st_nxt       = st;
        gnt_nxt      = gnt;
        last_gnt_nxt = last_gnt;
        err_rid_nxt  = err_rid;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        i_arready    = 1'b0;
        d_arready    = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        m_arid       = gnt_id;
        m_araddr     = gnt ? d_araddr : i_araddr;
        m_arlen      = gnt ? d_arlen  : i_arlen;
        m_arsize     = gnt ? d_arsize : i_arsize;

        case (st)
            IDLE: begin
                if (i_arvalid || d_arvalid) begin
                    st_nxt = ADDR;
                    if (i_arvalid && d_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
                        gnt_nxt = ~last_gnt;
`else
                        gnt_nxt = 1'b1;
`endif
                    end else begin
                        gnt_nxt = d_arvalid;
                    end
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (gnt) d_arready = m_arready;
                else     i_arready = m_arready;
                if (m_arready) begin
                    st_nxt       = DATA;
                    last_gnt_nxt = gnt;
                end
            end
            DATA: begin
                m_rready = gnt ? d_rready : i_rready;
                if (gnt) d_rvalid = m_rvalid;
                else     i_rvalid = m_rvalid;
                if (m_rvalid && (m_rid != gnt_id)) err_rid_nxt = 1'b1;
                if (m_rvalid && m_rready && m_rlast) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed bench for axi_read_arbiter. A behavioural AXI
// slave returns bursts; the expected beats are queued when driven and popped
// when the granted requester accepts them.
module tb_axi_read_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic [31:0] i_araddr, i_rdata;
    logic [7:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic [31:0] d_araddr, d_rdata;
    logic [7:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic [3:0]  m_arid, m_arcache, m_rid;
    logic [31:0] m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize, m_arprot;
    logic [1:0]  m_arburst, m_arlock, m_rresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, err_rid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t sbq[$];

    always #5 aclk = ~aclk;

    axi_read_arbiter #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
        .d_rready(d_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .err_rid(err_rid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the AR request of the expected side, check it, then complete
    // the handshake after 'delay' cycles of m_arready low.
    task automatic ar_phase(input logic side, input logic [31:0] addr,
                            input logic [7:0] len, input int delay);
        int n = 0;
        #1;
        while (m_arvalid !== 1'b1 && n < 20) begin
            @(posedge aclk); #2;
            n++;
        end
        chk("ar_latency", n, 1);
        chk("ar_id", m_arid, side ? 4'd1 : 4'd0);
        chk("ar_addr", m_araddr, addr);
        chk("ar_len", m_arlen, len);
        chk("ar_size_burst", {m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}, {3'd2, 2'b01, 9'd0});
        for (int k = 0; k <= delay; k++) begin
            m_arready = (k == delay);
            #1;
            chk("ar_hold_valid", m_arvalid, 1);
            chk("ar_hold_addr", m_araddr, addr);
            chk("ar_ready_gnt", side ? d_arready : i_arready, (k == delay));
            chk("ar_ready_other", side ? i_arready : d_arready, 0);
            @(posedge aclk); #1;
        end
        m_arready = 1'b0;
        if (side) d_arvalid = 1'b0;
        else      i_arvalid = 1'b0;
    endtask

    // Return len+1 beats to the granted side. Optional stall beat, beat with a
    // wrong rid, and beat during which reset is asserted (-1 disables each).
    task automatic r_phase(input logic side, input logic [7:0] len, input int stall_beat,
                           input int bad_beat, input int rst_beat);
        beat_t e, got;
        i_rready = 1'b1;
        d_rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            e.data  = $urandom;
            e.last  = (b == int'(len));
            m_rvalid = 1'b1;
            m_rdata  = e.data;
            m_rlast  = e.last;
            m_rid    = (b == bad_beat) ? 4'd3 : (side ? 4'd1 : 4'd0);
            m_rresp  = 2'b00;
            sbq.push_back(e);
            if (b == stall_beat) begin
                if (side) d_rready = 1'b0;
                else      i_rready = 1'b0;
                #1;
                chk("stall_rready", m_rready, 0);
                chk("stall_rvalid", side ? d_rvalid : i_rvalid, 1);
                chk("stall_rdata", side ? d_rdata : i_rdata, e.data);
                @(posedge aclk); #1;
                i_rready = 1'b1;
                d_rready = 1'b1;
            end
            if (b == rst_beat) begin
                #1;
                aresetn = 1'b0;
                #1;
                chk("rst_rready", m_rready, 0);
                chk("rst_arvalid", m_arvalid, 0);
                chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                sbq.delete();
                @(negedge aclk);
                aresetn = 1'b1;
                @(posedge aclk); #1;
                return;
            end
            #1;
            chk("r_valid_gnt", side ? d_rvalid : i_rvalid, 1);
            chk("r_valid_other", side ? i_rvalid : d_rvalid, 0);
            chk("r_ready", m_rready, 1);
            if (sbq.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                got = sbq.pop_front();
                chk("r_data", side ? d_rdata : i_rdata, got.data);
                chk("r_last", side ? d_rlast : i_rlast, got.last);
            end
            @(posedge aclk); #1;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("idle_gap_arvalid", m_arvalid, 0);
        chk("idle_gap_rready", m_rready, 0);
    endtask

    initial begin : stim
        logic last_side;
        logic exp_side;
        aresetn   = 1'b0;
        i_arvalid = 1'b0; i_araddr = '0; i_arlen = '0; i_arsize = 3'd2; i_rready = 1'b0;
        d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_arsize = 3'd2; d_rready = 1'b0;
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        #12;
        chk("reset_outputs", {m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid, err_rid}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // instruction-only burst of 8 beats
        m_arready = 1'b1;
        i_araddr = 32'hBFC0_0000; i_arlen = 8'd7; i_arvalid = 1'b1;
        #1;
        chk("idle_no_arvalid", m_arvalid, 0);
        chk("idle_no_arready", i_arready, 0);
        ar_phase(1'b0, 32'hBFC0_0000, 8'd7, 0);
        r_phase(1'b0, 8'd7, -1, -1, -1);
        chk("err_rid_clean", err_rid, 0);

        // simultaneous requests: data first, instruction after one idle cycle
        i_araddr = 32'h0000_1000; i_arlen = 8'd3; i_arvalid = 1'b1;
        d_araddr = 32'h0000_2000; d_arlen = 8'd1; d_arvalid = 1'b1;
        ar_phase(1'b1, 32'h0000_2000, 8'd1, 0);
        r_phase(1'b1, 8'd1, -1, -1, -1);
        ar_phase(1'b0, 32'h0000_1000, 8'd3, 0);
        r_phase(1'b0, 8'd3, -1, -1, -1);
        last_side = 1'b0;

        // both sides keep requesting; winner re-requests after each burst
        i_arvalid = 1'b1;
        d_arvalid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            i_araddr = 32'h0001_0000 + 32'(r * 64); i_arlen = 8'd2;
            d_araddr = 32'h0002_0000 + 32'(r * 64); d_arlen = 8'd1;
            i_arvalid = 1'b1;
            d_arvalid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_side = ~last_side;
`else
            exp_side = 1'b1;
`endif
            ar_phase(exp_side, exp_side ? d_araddr : i_araddr, exp_side ? 8'd1 : 8'd2, 0);
            r_phase(exp_side, exp_side ? 8'd1 : 8'd2, -1, -1, -1);
            last_side = exp_side;
        end
        d_arvalid = 1'b0;
        if (i_arvalid) begin
            ar_phase(1'b0, i_araddr, 8'd2, 0);
            r_phase(1'b0, 8'd2, -1, -1, -1);
        end

        // AR held off by slave for 5 cycles
        i_araddr = 32'h0000_3000; i_arlen = 8'd1; i_arvalid = 1'b1;
        ar_phase(1'b0, 32'h0000_3000, 8'd1, 5);
        r_phase(1'b0, 8'd1, -1, -1, -1);

        // requester back-pressure and a beat with a foreign rid
        d_araddr = 32'h0000_4000; d_arlen = 8'd7; d_arvalid = 1'b1;
        ar_phase(1'b1, 32'h0000_4000, 8'd7, 0);
        r_phase(1'b1, 8'd7, 2, 4, -1);
        chk("err_rid_set", err_rid, 1);
        i_araddr = 32'h0000_5000; i_arlen = 8'd0; i_arvalid = 1'b1;
        ar_phase(1'b0, 32'h0000_5000, 8'd0, 0);
        r_phase(1'b0, 8'd0, -1, -1, -1);
        chk("err_rid_sticky", err_rid, 1);

        // reset during beat 3 of 8, then recover with a fresh burst
        i_araddr = 32'h0000_6000; i_arlen = 8'd7; i_arvalid = 1'b1;
        ar_phase(1'b0, 32'h0000_6000, 8'd7, 0);
        r_phase(1'b0, 8'd7, -1, -1, 2);
        #1;
        chk("post_rst_err", err_rid, 0);
        chk("post_rst_idle", {m_arvalid, m_rready}, 0);
        i_araddr = 32'h0000_7000; i_arlen = 8'd1; i_arvalid = 1'b1;
        ar_phase(1'b0, 32'h0000_7000, 8'd1, 0);
        r_phase(1'b0, 8'd1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
